// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel frame sequencer.
package pixel_pkg;

  localparam int unsigned PIXEL_BITS = 8;
  localparam int unsigned TIMER_BITS = 16;

  // Default frame timing, in clock cycles.
  localparam int unsigned DEF_ERASE_CYCLES  = 4;
  localparam int unsigned DEF_SETTLE_CYCLES = 2;
  localparam int unsigned DEF_CONV_TIMEOUT  = 300;

  typedef enum logic [2:0] {
    StIdle,
    StErase,
    StExpose,
    StAdcRst,
    StConvert,
    StSettle,
    StOutput
  } frame_state_t;

  // A zero exposure request still exposes for one cycle.
  function automatic logic [TIMER_BITS-1:0] clamp_exp(input logic [TIMER_BITS-1:0] t);
    return (t == '0) ? TIMER_BITS'(1) : t;
  endfunction

endpackage

// File: rtl/pixel_frame_controller_if.sv
// Camera-control, pixel-array and ADC signals of the frame sequencer.
interface pixel_frame_controller_if #(
  parameter int unsigned NUM_ROWS = 2,
  parameter int unsigned NUM_COLS = 2
);
  import pixel_pkg::*;

  localparam int unsigned ROW_IDX_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  logic                           start;
  logic                           abort;
  logic [TIMER_BITS-1:0]          exp_time;
  logic                           adc_finished;
  logic                           adc_enable;
  logic                           adc_reset;
  logic                           erase;
  logic                           expose;
  logic [NUM_ROWS-1:0]            row_sel;
  logic [NUM_COLS*PIXEL_BITS-1:0] pixel_data;
  logic [NUM_COLS*PIXEL_BITS-1:0] data_out;
  logic                           data_valid;
  logic                           data_ready;
  logic [ROW_IDX_W-1:0]           row_idx;
  logic                           busy;
  logic                           frame_done;
  logic                           conv_error;

  // Sequencer side.
  modport master (
    input  start, abort, exp_time, adc_finished, pixel_data, data_ready,
    output adc_enable, adc_reset, erase, expose, row_sel, data_out, data_valid, row_idx,
           busy, frame_done, conv_error
  );

  // Camera control / array / ADC side.
  modport slave (
    output start, abort, exp_time, adc_finished, pixel_data, data_ready,
    input  adc_enable, adc_reset, erase, expose, row_sel, data_out, data_valid, row_idx,
           busy, frame_done, conv_error
  );

endinterface

// File: rtl/cycle_timer.sv
// Loadable down-counter; done marks the last cycle of the loaded interval.
module cycle_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count_q;

  // Load wins; otherwise count down and rest at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign done = (count_q == WIDTH'(1));

endmodule

// File: rtl/pixel_frame_controller.sv
// Frame sequencer: erase, expose, ramp ADC conversion, then row-by-row readout.
module pixel_frame_controller
  import pixel_pkg::*;
#(
  parameter int unsigned NUM_ROWS      = 2,
  parameter int unsigned NUM_COLS      = 2,
  parameter int unsigned ERASE_CYCLES  = DEF_ERASE_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned CONV_TIMEOUT  = DEF_CONV_TIMEOUT
) (
  input logic                      clk,
  input logic                      reset,
  pixel_frame_controller_if.master bus
);

  localparam int unsigned ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int unsigned DATA_W = NUM_COLS * PIXEL_BITS;

  localparam logic [ROW_W-1:0]      LAST_ROW    = ROW_W'(NUM_ROWS - 1);
  localparam logic [TIMER_BITS-1:0] ERASE_LOAD  = TIMER_BITS'(ERASE_CYCLES);
  localparam logic [TIMER_BITS-1:0] SETTLE_LOAD = TIMER_BITS'(SETTLE_CYCLES);
  localparam logic [TIMER_BITS-1:0] CONV_LOAD   = TIMER_BITS'(CONV_TIMEOUT);

  frame_state_t          state_q;
  logic [TIMER_BITS-1:0] exp_q;
  logic [ROW_W-1:0]      row_q;
  logic [NUM_ROWS-1:0]   row_sel_q;
  logic [DATA_W-1:0]     data_q;
  logic [ROW_W-1:0]      row_idx_q;
  logic erase_q, expose_q, adc_reset_q, adc_enable_q;
  logic data_valid_q, frame_done_q, conv_error_q;

  logic                  timer_load;
  logic [TIMER_BITS-1:0] timer_val;
  logic                  timer_done;
  logic                  last_row;

  assign last_row = (row_q == LAST_ROW);

  // One shared timer: load it on every edge that enters a timed interval.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !frame_done_q) begin
          timer_load = 1'b1;
          timer_val  = ERASE_LOAD;
        end
      end
      StErase: begin
        if (timer_done) begin
          timer_load = 1'b1;
          timer_val  = exp_q;
        end
      end
      StAdcRst: begin
        timer_load = 1'b1;
        timer_val  = CONV_LOAD;
      end
      StConvert: begin
        if (bus.adc_finished) begin
          timer_load = 1'b1;
          timer_val  = SETTLE_LOAD;
        end
      end
      StOutput: begin
        if (data_valid_q && bus.data_ready && !last_row) begin
          timer_load = 1'b1;
          timer_val  = SETTLE_LOAD;
        end
      end
      default: ;
    endcase
  end

  cycle_timer #(
    .WIDTH (TIMER_BITS)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  // Frame state machine with registered outputs; abort overrides all but IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      exp_q        <= '0;
      row_q        <= '0;
      row_sel_q    <= '0;
      data_q       <= '0;
      row_idx_q    <= '0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      adc_reset_q  <= 1'b0;
      adc_enable_q <= 1'b0;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      conv_error_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (bus.abort && (state_q != StIdle)) begin
        state_q      <= StIdle;
        row_q        <= '0;
        row_sel_q    <= '0;
        erase_q      <= 1'b0;
        expose_q     <= 1'b0;
        adc_reset_q  <= 1'b0;
        adc_enable_q <= 1'b0;
        data_valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            // Ignore start during the frame_done cycle.
            if (bus.start && !frame_done_q) begin
              exp_q        <= clamp_exp(bus.exp_time);
              conv_error_q <= 1'b0;
              erase_q      <= 1'b1;
              state_q      <= StErase;
            end
          end
          StErase: begin
            if (timer_done) begin
              erase_q  <= 1'b0;
              expose_q <= 1'b1;
              state_q  <= StExpose;
            end
          end
          StExpose: begin
            if (timer_done) begin
              expose_q    <= 1'b0;
              adc_reset_q <= 1'b1;
              state_q     <= StAdcRst;
            end
          end
          StAdcRst: begin
            adc_reset_q  <= 1'b0;
            adc_enable_q <= 1'b1;
            state_q      <= StConvert;
          end
          StConvert: begin
            if (bus.adc_finished) begin
              adc_enable_q <= 1'b0;
              row_q        <= '0;
              row_sel_q    <= NUM_ROWS'(1);
              state_q      <= StSettle;
            end else if (timer_done) begin
              adc_enable_q <= 1'b0;
              conv_error_q <= 1'b1;
              state_q      <= StIdle;
            end
          end
          StSettle: begin
            if (timer_done) begin
              data_q       <= bus.pixel_data;
              row_idx_q    <= row_q;
              data_valid_q <= 1'b1;
              state_q      <= StOutput;
            end
          end
          StOutput: begin
            if (data_valid_q && bus.data_ready) begin
              data_valid_q <= 1'b0;
              if (last_row) begin
                row_q        <= '0;
                row_sel_q    <= '0;
                frame_done_q <= 1'b1;
                state_q      <= StIdle;
              end else begin
                row_q     <= row_q + ROW_W'(1);
                row_sel_q <= row_sel_q << 1;
                state_q   <= StSettle;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.adc_enable = adc_enable_q;
  assign bus.adc_reset  = adc_reset_q;
  assign bus.erase      = erase_q;
  assign bus.expose     = expose_q;
  assign bus.row_sel    = row_sel_q;
  assign bus.data_out   = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.row_idx    = row_idx_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.frame_done = frame_done_q;
  assign bus.conv_error = conv_error_q;

endmodule

// File: tb/tb_pixel_frame_controller.sv
// Bench for pixel_frame_controller: per-frame event counts versus the frame rules.
module tb_pixel_frame_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pixel_frame_controller_if #(.NUM_ROWS(2), .NUM_COLS(2)) bus ();

  pixel_frame_controller #(
    .NUM_ROWS      (2),
    .NUM_COLS      (2),
    .ERASE_CYCLES  (4),
    .SETTLE_CYCLES (2),
    .CONV_TIMEOUT  (300)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Pixel array model: each row presents its own fixed code when selected.
  logic [15:0] pix [2];
  assign bus.pixel_data = (bus.row_sel == 2'b01) ? pix[0] :
                          (bus.row_sel == 2'b10) ? pix[1] : 16'h0000;

  // Responder settings and monitor tallies.
  int adc_delay = 0;   // finished asserted on this enable cycle; 0 = never
  int en_cyc = 0;
  int bp_need = 0;
  int bp_hold = 0;
  bit poke_expose = 0;
  bit poke_clear = 0;
  int m_erase, m_expose, m_adcrst, m_enable, m_done, m_stall;
  logic [15:0] acc_data [$];
  int acc_idx [$];
  logic prev_dv = 0, prev_dr = 0, prev_ri = 0;
  logic [15:0] prev_do = 0;
  logic [1:0] prev_rs = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_monitor();
    m_erase = 0; m_expose = 0; m_adcrst = 0; m_enable = 0; m_done = 0; m_stall = 0;
    acc_data.delete();
    acc_idx.delete();
  endtask

  // ADC, downstream-ready and stray-start responders, driven just after each edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (bus.adc_enable) begin
      en_cyc++;
      bus.adc_finished = (adc_delay != 0) && (en_cyc == adc_delay);
    end else begin
      en_cyc = 0;
      bus.adc_finished = 1'b0;
    end
    if (bus.data_valid && bp_hold < bp_need) begin
      bus.data_ready = 1'b0;
      bp_hold++;
    end else begin
      bus.data_ready = 1'b1;
    end
    if (poke_expose && bus.expose) begin
      bus.start = 1'b1;
      poke_expose = 0;
      poke_clear = 1;
    end else if (poke_clear) begin
      bus.start = 1'b0;
      poke_clear = 0;
    end
  end

  // Monitor: tally control pulses, record accepted rows, check holds under backpressure.
  initial forever begin
    @(negedge clk);
    if (bus.erase) m_erase++;
    if (bus.expose) m_expose++;
    if (bus.adc_reset) m_adcrst++;
    if (bus.adc_enable) m_enable++;
    if (bus.frame_done) m_done++;
    if (prev_dv && !prev_dr) begin
      m_stall++;
      check("hold_valid", 64'(bus.data_valid), 64'(1));
      check("hold_data", 64'(bus.data_out), 64'(prev_do));
      check("hold_row_sel", 64'(bus.row_sel), 64'(prev_rs));
      check("hold_row_idx", 64'(bus.row_idx), 64'(prev_ri));
    end
    if (bus.data_valid && bus.data_ready) begin
      acc_data.push_back(bus.data_out);
      acc_idx.push_back(int'(bus.row_idx));
    end
    prev_dv = bus.data_valid;
    prev_dr = bus.data_ready;
    prev_do = bus.data_out;
    prev_rs = bus.row_sel;
    prev_ri = bus.row_idx;
  end

  function automatic logic [63:0] all_outputs();
    return 64'({bus.adc_enable, bus.adc_reset, bus.erase, bus.expose, bus.row_sel,
                bus.data_out, bus.data_valid, bus.row_idx, bus.busy, bus.frame_done,
                bus.conv_error});
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
  endtask

  // One frame; delay 0 means the ADC never finishes.
  task automatic run_frame(input string name, input logic [15:0] exp, input int delay,
                           input int bp, input bit poke);
    int guard;
    bit tmo;
    int exp_cycles;
    tmo = (delay == 0);
    exp_cycles = (exp == 16'd0) ? 1 : int'(exp);
    bus.exp_time = exp;
    adc_delay = delay;
    bp_need = bp;
    bp_hold = 0;
    poke_expose = poke;
    clear_monitor();
    pulse_start();
    check({name, "/erase_first_cycle"}, 64'(bus.erase), 64'(1));
    check({name, "/busy"}, 64'(bus.busy), 64'(1));
    check({name, "/conv_error_cleared"}, 64'(bus.conv_error), 64'(0));
    guard = 0;
    while (bus.busy && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    check({name, "/frame_ends"}, 64'(bus.busy), 64'(0));
    check({name, "/frame_done"}, 64'(bus.frame_done), 64'(!tmo));
    check({name, "/conv_error"}, 64'(bus.conv_error), 64'(tmo));
    @(posedge clk); #1;
    check({name, "/frame_done_one_cycle"}, 64'(bus.frame_done), 64'(0));
    @(posedge clk); #1;
    check({name, "/erase_cycles"}, 64'(m_erase), 64'(4));
    check({name, "/expose_cycles"}, 64'(m_expose), 64'(exp_cycles));
    check({name, "/adc_reset_cycles"}, 64'(m_adcrst), 64'(1));
    check({name, "/adc_enable_cycles"}, 64'(m_enable), 64'(tmo ? 300 : delay));
    check({name, "/frame_done_count"}, 64'(m_done), 64'(tmo ? 0 : 1));
    check({name, "/stall_cycles"}, 64'(m_stall), 64'(tmo ? 0 : bp));
    check({name, "/rows_accepted"}, 64'(acc_data.size()), 64'(tmo ? 0 : 2));
    for (int k = 0; k < acc_data.size() && k < 2; k++) begin
      check({name, "/row_idx"}, 64'(acc_idx[k]), 64'(k));
      check({name, "/row_data"}, 64'(acc_data[k]), 64'(pix[k]));
    end
  endtask

  initial begin
    int guard;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.exp_time = 16'd0;
    bus.adc_finished = 1'b0;
    bus.data_ready = 1'b1;
    pix[0] = 16'hA55A;
    pix[1] = 16'h0FF0;

    #12;
    check("reset_outputs", all_outputs(), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_outputs", all_outputs(), 64'(0));

    run_frame("nominal", 16'd10, 256, 0, 0);
    run_frame("backpressure", 16'd3, 7, 5, 0);
    run_frame("exp_zero_stray_start", 16'd0, 4, 0, 1);
    run_frame("adc_first_cycle", 16'd2, 1, 0, 0);
    run_frame("conv_timeout", 16'd5, 0, 0, 0);
    run_frame("after_timeout", 16'd1, 3, 1, 0);

    // Abort during the settle of the second row.
    bus.exp_time = 16'd3;
    adc_delay = 5;
    bp_need = 0;
    bp_hold = 0;
    clear_monitor();
    pulse_start();
    guard = 0;
    while (!(bus.row_sel == 2'b10 && !bus.data_valid) && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("abort/reached_row1_settle", 64'(bus.row_sel), 64'(2'b10));
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort/busy", 64'(bus.busy), 64'(0));
    check("abort/row_sel", 64'(bus.row_sel), 64'(0));
    check("abort/data_valid", 64'(bus.data_valid), 64'(0));
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("abort/frame_done_count", 64'(m_done), 64'(0));
    check("abort/rows_accepted", 64'(acc_data.size()), 64'(1));
    check("abort/conv_error", 64'(bus.conv_error), 64'(0));

    // Asynchronous reset in the middle of exposure, away from the clock edge.
    bus.exp_time = 16'd20;
    adc_delay = 10;
    pulse_start();
    guard = 0;
    while (!bus.expose && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("reset_mid/reached_expose", 64'(bus.expose), 64'(1));
    #3 reset = 1'b1;
    #1;
    check("reset_mid/outputs_cleared", all_outputs(), 64'(0));
    #3 reset = 1'b0;
    run_frame("after_reset", 16'd6, 12, 2, 0);

    for (int i = 0; i < 5; i++) begin
      pix[0] = 16'($urandom);
      pix[1] = 16'($urandom);
      run_frame("random", 16'($urandom_range(0, 20)), int'($urandom_range(1, 40)),
                int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
